// File: rtl/instr_assembler_if.sv
//------------------------------------------------------------------------------
// instr_assembler_if : bus-beat input and committed-instruction output bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instr_assembler_if #(
  parameter int BUS_W   = 8,
  parameter int INSTR_W = 16
);
  localparam int CNT_W = $clog2(INSTR_W / BUS_W);

  logic [BUS_W-1:0]   data;
  logic               ena;
  logic               clr;
  logic [INSTR_W-1:0] opc_iraddr;
  logic               ir_done;
  logic               ir_valid;
  logic               busy;
  logic [CNT_W-1:0]   beat_cnt;

  modport master (
    output data, ena, clr,
    input  opc_iraddr, ir_done, ir_valid, busy, beat_cnt
  );

  modport slave (
    input  data, ena, clr,
    output opc_iraddr, ir_done, ir_valid, busy, beat_cnt
  );
endinterface

`default_nettype wire

// File: rtl/instr_assembler.sv
//------------------------------------------------------------------------------
// instr_assembler : builds an instruction from BEATS bus beats in a shadow
// register and commits it atomically on the final beat.   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_assembler #(
  parameter int                 BUS_W     = 8,
  parameter int                 INSTR_W   = 16,
  parameter int                 MSB_FIRST = 1,
  parameter logic [INSTR_W-1:0] RST_VAL   = '0
) (
  input  wire              clk1,
  input  wire              rst,
  instr_assembler_if.slave bus
);
  localparam int BEATS = INSTR_W / BUS_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int SH_W  = INSTR_W - BUS_W;

  generate
    if ((INSTR_W % BUS_W) != 0 || BEATS < 2) begin : g_bad_params
      $error("instr_assembler: INSTR_W must be a multiple of BUS_W with at least 2 beats");
    end
  endgenerate

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic [SH_W-1:0]    r_shadow;
  logic [INSTR_W-1:0] r_opc;
  logic               r_done;
  logic               r_valid;
  logic               w_capture;
  logic               w_commit;
  logic               w_clear;
  logic               w_first;
  logic               w_last;
  logic [INSTR_W-1:0] w_assembled;

  assign w_last = (r_beat_cnt == CNT_W'(BEATS - 1));

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_assembled = {r_shadow, bus.data};
    end else begin : g_lsb_first
      assign w_assembled = {bus.data, r_shadow};
    end
  endgenerate

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_beat_cnt;
    w_capture  = 1'b0;
    w_commit   = 1'b0;
    w_clear    = 1'b0;
    w_first    = 1'b0;
    if (bus.clr) begin
      w_clear    = 1'b1;
      w_cnt_nx   = '0;
      w_state_nx = S_IDLE;
    end else if (bus.ena) begin
      if (w_last) begin
        w_commit   = 1'b1;
        w_cnt_nx   = '0;
        w_state_nx = S_IDLE;
      end else begin
        w_capture  = 1'b1;
        w_first    = (r_beat_cnt == '0);
        w_cnt_nx   = r_beat_cnt + 1'b1;
        w_state_nx = S_FILL;
      end
    end else begin
      // Dropping the strobe abandons any partial word; shadow contents are simply overwritten later
      w_cnt_nx   = '0;
      w_state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
      r_shadow   <= '0;
      r_opc      <= RST_VAL;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_beat_cnt <= w_cnt_nx;
      r_done     <= w_commit;
      if (w_clear) begin
        r_shadow <= '0;
        r_opc    <= RST_VAL;
        r_valid  <= 1'b0;
      end else if (w_commit) begin
        r_opc   <= w_assembled;
        r_valid <= 1'b1;
      end else if (w_capture) begin
        if (w_first) begin
          r_valid <= 1'b0;
        end
        for (int i = 0; i < BEATS - 1; i++) begin
          if (r_beat_cnt == CNT_W'(i)) begin
            r_shadow[((MSB_FIRST != 0) ? (SH_W - (i + 1) * BUS_W) : (i * BUS_W)) +: BUS_W] <= bus.data;
          end
        end
      end
    end
  end

  assign bus.opc_iraddr = r_opc;
  assign bus.ir_done    = r_done;
  assign bus.ir_valid   = r_valid;
  assign bus.busy       = (r_state == S_FILL);
  assign bus.beat_cnt   = r_beat_cnt;

endmodule

`default_nettype wire

// File: tb/tb_instr_assembler.sv
//------------------------------------------------------------------------------
// tb_instr_assembler : directed vectors with a per-DUT expected-instruction
// scoreboard popped whenever ir_done pulses.   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_assembler;
  logic clk1;
  logic rst;
  int   vectors;
  int   miscompares;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];

  instr_assembler_if #(.BUS_W(8), .INSTR_W(16)) ia();
  instr_assembler_if #(.BUS_W(8), .INSTR_W(16)) ib();
  instr_assembler_if #(.BUS_W(8), .INSTR_W(32)) ic();

  instr_assembler #(.BUS_W(8), .INSTR_W(16), .MSB_FIRST(1), .RST_VAL(16'h0000))
    u_a (.clk1(clk1), .rst(rst), .bus(ia));
  instr_assembler #(.BUS_W(8), .INSTR_W(16), .MSB_FIRST(0), .RST_VAL(16'h0000))
    u_b (.clk1(clk1), .rst(rst), .bus(ib));
  instr_assembler #(.BUS_W(8), .INSTR_W(32), .MSB_FIRST(1), .RST_VAL(32'h0))
    u_c (.clk1(clk1), .rst(rst), .bus(ic));

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  // Scoreboard monitor: every ir_done pulse must match the oldest expected instruction
  always @(negedge clk1) begin
    if (ia.ir_done) begin
      if (qa.size() == 0) chk("a_unexpected_done", 32'd1, 32'd0);
      else begin
        logic [31:0] e;
        e = qa.pop_front();
        chk("a_commit_opc", 32'(ia.opc_iraddr), e);
        chk("a_commit_valid", 32'(ia.ir_valid), 32'd1);
      end
    end
    if (ib.ir_done) begin
      if (qb.size() == 0) chk("b_unexpected_done", 32'd1, 32'd0);
      else begin
        logic [31:0] e;
        e = qb.pop_front();
        chk("b_commit_opc", 32'(ib.opc_iraddr), e);
      end
    end
    if (ic.ir_done) begin
      if (qc.size() == 0) chk("c_unexpected_done", 32'd1, 32'd0);
      else begin
        logic [31:0] e;
        e = qc.pop_front();
        chk("c_commit_opc", ic.opc_iraddr, e);
      end
    end
  end

  initial begin
    logic [7:0] beats_c [4];
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0;
    ia.data = '0; ia.ena = 1'b0; ia.clr = 1'b0;
    ib.data = '0; ib.ena = 1'b0; ib.clr = 1'b0;
    ic.data = '0; ic.ena = 1'b0; ic.clr = 1'b0;
    #12 rst = 1'b1;
    step();

    // Reset state
    chk("rst_a_opc",   32'(ia.opc_iraddr), 32'h0);
    chk("rst_a_valid", 32'(ia.ir_valid),   32'd0);
    chk("rst_a_busy",  32'(ia.busy),       32'd0);
    chk("rst_a_cnt",   32'(ia.beat_cnt),   32'd0);
    chk("rst_a_done",  32'(ia.ir_done),    32'd0);
    chk("rst_c_opc",   ic.opc_iraddr,      32'h0);

    // Tests 1 and 2: A5,3C into MSB-first and LSB-first assemblers together
    ia.ena = 1'b1; ib.ena = 1'b1; ia.data = 8'hA5; ib.data = 8'hA5;
    qa.push_back(32'hA53C); qb.push_back(32'h3CA5);
    step();
    chk("t1_cnt_beat1",  32'(ia.beat_cnt),   32'd1);
    chk("t1_busy_beat1", 32'(ia.busy),       32'd1);
    chk("t1_opc_beat1",  32'(ia.opc_iraddr), 32'h0);
    chk("t1_done_beat1", 32'(ia.ir_done),    32'd0);
    ia.data = 8'h3C; ib.data = 8'h3C;
    step();
    chk("t1_cnt_wrap",  32'(ia.beat_cnt),   32'd0);
    chk("t1_busy_end",  32'(ia.busy),       32'd0);
    chk("t1_opc",       32'(ia.opc_iraddr), 32'hA53C);
    chk("t1_done",      32'(ia.ir_done),    32'd1);
    chk("t2_opc",       32'(ib.opc_iraddr), 32'h3CA5);
    chk("t2_valid",     32'(ib.ir_valid),   32'd1);
    ia.ena = 1'b0; ib.ena = 1'b0;
    step();
    chk("t1_done_one_cycle", 32'(ia.ir_done),  32'd0);
    chk("t1_valid_sticky",   32'(ia.ir_valid), 32'd1);

    // Test 3: 32-bit word, loaded twice to observe old value held and valid dropping
    beats_c = '{8'h11, 8'h22, 8'h33, 8'h44};
    ic.ena = 1'b1;
    qc.push_back(32'h11223344);
    for (int i = 0; i < 4; i++) begin
      ic.data = beats_c[i];
      step();
      if (i < 3) chk("t3_opc_hold0", ic.opc_iraddr, 32'h0);
    end
    chk("t3_opc",   ic.opc_iraddr,     32'h11223344);
    chk("t3_valid", 32'(ic.ir_valid),  32'd1);
    beats_c = '{8'h55, 8'h66, 8'h77, 8'h88};
    qc.push_back(32'h55667788);
    for (int i = 0; i < 4; i++) begin
      ic.data = beats_c[i];
      step();
      if (i < 3) begin
        chk("t3_opc_hold",   ic.opc_iraddr,    32'h11223344);
        chk("t3_valid_low",  32'(ic.ir_valid), 32'd0);
        chk("t3_cnt",        32'(ic.beat_cnt), 32'(i + 1));
      end
    end
    chk("t3_opc2", ic.opc_iraddr, 32'h55667788);
    ic.ena = 1'b0;

    // Test 4: stale FF beat dropped when ena falls
    ia.ena = 1'b1; ia.data = 8'hFF;
    step();
    ia.ena = 1'b0;
    step();
    chk("t4_cnt_abandon",  32'(ia.beat_cnt),   32'd0);
    chk("t4_busy_abandon", 32'(ia.busy),       32'd0);
    chk("t4_opc_keep",     32'(ia.opc_iraddr), 32'hA53C);
    chk("t4_valid_low",    32'(ia.ir_valid),   32'd0);
    ia.ena = 1'b1; ia.data = 8'h12; qa.push_back(32'h1234);
    step();
    ia.data = 8'h34;
    step();
    chk("t4_opc", 32'(ia.opc_iraddr), 32'h1234);

    // Test 5: back-to-back instructions with ena held
    ia.data = 8'h01; qa.push_back(32'h0102); qa.push_back(32'h0304);
    step();
    ia.data = 8'h02;
    step();
    chk("t5_opc_first", 32'(ia.opc_iraddr), 32'h0102);
    ia.data = 8'h03;
    step();
    chk("t5_done_gap", 32'(ia.ir_done), 32'd0);
    ia.data = 8'h04;
    step();
    chk("t5_opc_second", 32'(ia.opc_iraddr), 32'h0304);

    // Test 6: asynchronous reset mid-sequence, then reload, then clr beats ena
    ia.data = 8'h77;
    step();
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_opc",   32'(ia.opc_iraddr), 32'h0);
    chk("t6_rst_cnt",   32'(ia.beat_cnt),   32'd0);
    chk("t6_rst_busy",  32'(ia.busy),       32'd0);
    chk("t6_rst_valid", 32'(ia.ir_valid),   32'd0);
    #2 rst = 1'b1;
    ia.data = 8'hAA; qa.push_back(32'hAABB);
    step();
    ia.data = 8'hBB;
    step();
    chk("t6_opc", 32'(ia.opc_iraddr), 32'hAABB);
    ia.clr = 1'b1; ia.data = 8'h55;
    step();
    chk("t6_clr_opc",   32'(ia.opc_iraddr), 32'h0);
    chk("t6_clr_valid", 32'(ia.ir_valid),   32'd0);
    chk("t6_clr_cnt",   32'(ia.beat_cnt),   32'd0);
    chk("t6_clr_done",  32'(ia.ir_done),    32'd0);
    ia.clr = 1'b0; ia.ena = 1'b0;
    step();
    step();

    chk("sb_a_drained", 32'(qa.size()), 32'd0);
    chk("sb_b_drained", 32'(qb.size()), 32'd0);
    chk("sb_c_drained", 32'(qc.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
